add_result_fifo: RTL and testbench

- Downstream stage of adder64. Captures each sum qualified by the adder's rdy pulse into a small result FIFO.
- Presents the results to the consumer over a valid/ready handshake.
- adder64 has no backpressure, so this block absorbs bursts, drops on full, and reports every loss through a sticky overflow flag and a drop counter.

---
 rtl/add_result_fifo_if.sv | 10 +
 rtl/add_result_fifo.sv | 64 ++++++
 tb/tb_add_result_fifo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/add_result_fifo_if.sv
// add_result_fifo_if: producer push strobe/data and consumer valid/ready handshake for add_result_fifo.
interface add_result_fifo_if #(parameter int LEN_DATA = 64);
    logic                in_rdy;
    logic [LEN_DATA-1:0] in_sum;
    logic                out_valid;
    logic [LEN_DATA-1:0] out_data;
    logic                out_ready;
    modport master (output in_rdy, in_sum, out_ready, input out_valid, out_data);
    modport slave  (input in_rdy, in_sum, out_ready, output out_valid, out_data);
endinterface

// File: rtl/add_result_fifo.sv
// add_result_fifo: result FIFO behind adder64 with drop-on-full, sticky overflow and saturating drop counter.
// Define ADD_RESULT_FIFO_BYPASS_EN for a zero-latency bypass when the FIFO is empty and the consumer is ready.
`ifndef LEN_DATA
`define LEN_DATA 64
`endif
module add_result_fifo #(
    parameter int LEN_DATA = `LEN_DATA,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               ovf_clr,
    add_result_fifo_if.slave   bus,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [7:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    logic [LEN_DATA-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic                byp, pop, push, drop;
    logic [LEN_DATA-1:0] head;
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign head  = empty ? '0 : mem[rd_ptr];
`ifdef ADD_RESULT_FIFO_BYPASS_EN
    // The bypassed sum goes straight to the consumer and never occupies an entry.
    assign byp           = en & bus.in_rdy & empty & bus.out_ready;
    assign bus.out_valid = !empty | byp;
    assign bus.out_data  = byp ? bus.in_sum : head;
`else
    assign byp           = 1'b0;
    assign bus.out_valid = !empty;
    assign bus.out_data  = head;
`endif
    assign pop  = en & !empty & bus.out_ready;
    assign push = en & bus.in_rdy & (!full | pop) & !byp;
    assign drop = en & bus.in_rdy & full & !pop;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= bus.in_sum;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (ovf_clr) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt == 8'hFF ? drop_cnt : drop_cnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_add_result_fifo.sv
// tb_add_result_fifo: directed checks of ordering, drop accounting, enable gating, wrap, saturation and async reset.
module tb_add_result_fifo;
    logic       clk = 1'b0;
    logic       rst, en, ovf_clr;
    logic       full, empty, overflow;
    logic [2:0] count;
    logic [7:0] drop_cnt;
    int         total = 0;
    int         bad = 0;
    add_result_fifo_if #(.LEN_DATA(64)) bus ();
    add_result_fifo #(.LEN_DATA(64), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .ovf_clr(ovf_clr), .bus(bus),
        .full(full), .empty(empty), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            bus.in_sum = 64'(base + i);
            bus.in_rdy = 1'b1;
            tick();
        end
        bus.in_rdy = 1'b0;
    endtask
    task automatic drain_chk(input string tag, input logic [63:0] v0, v1, v2, v3);
        logic [63:0] exp [4];
        exp = '{v0, v1, v2, v3};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk(tag, bus.out_data, exp[i]);
            tick();
        end
        bus.out_ready = 1'b0;
        chk({tag, "_empty"}, 64'(empty), 64'd1);
    endtask
    initial begin
        rst = 1'b0; en = 1'b0; ovf_clr = 1'b0;
        bus.in_rdy = 1'b0; bus.in_sum = '0; bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1; en = 1'b1;
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_data", bus.out_data, 64'd0);
        bus.in_rdy = 1'b1; bus.in_sum = 64'h0000_0001_0000_0002; bus.out_ready = 1'b1;
`ifdef ADD_RESULT_FIFO_BYPASS_EN
        #1;
        chk("byp_valid", 64'(bus.out_valid), 64'd1);
        chk("byp_data", bus.out_data, 64'h0000_0001_0000_0002);
        tick();
        bus.in_rdy = 1'b0;
        chk("byp_count", 64'(count), 64'd0);
`else
        tick();
        bus.in_rdy = 1'b0;
        chk("single_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", bus.out_data, 64'h0000_0001_0000_0002);
        chk("single_count", 64'(count), 64'd1);
        tick();
        chk("single_empty", 64'(empty), 64'd1);
`endif
        bus.out_ready = 1'b0;
        push_n(6, 1);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_drop", 64'(drop_cnt), 64'd2);
        drain_chk("fill_drain", 64'd1, 64'd2, 64'd3, 64'd4);
        push_n(4, 1);
        bus.in_rdy = 1'b1; bus.in_sum = 64'd9; bus.out_ready = 1'b1;
        chk("pp_head", bus.out_data, 64'd1);
        tick();
        bus.in_rdy = 1'b0; bus.out_ready = 1'b0;
        chk("pp_count", 64'(count), 64'd4);
        chk("pp_drop", 64'(drop_cnt), 64'd2);
        drain_chk("pp_drain", 64'd2, 64'd3, 64'd4, 64'd9);
        push_n(4, 'h11);
        en = 1'b0; bus.in_rdy = 1'b1; bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("en_count", 64'(count), 64'd4);
        chk("en_drop", 64'(drop_cnt), 64'd2);
        chk("en_head", bus.out_data, 64'h11);
        bus.in_rdy = 1'b0; bus.out_ready = 1'b0; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0; en = 1'b1;
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_drop", 64'(drop_cnt), 64'd0);
        drain_chk("en_drain", 64'h11, 64'h12, 64'h13, 64'h14);
        for (int i = 0; i < 10; i++) begin
            bus.in_sum = 64'(100 + i);
            bus.in_rdy = 1'b1;
            bus.out_ready = i > 0;
            if (i > 0) chk("wrap_data", bus.out_data, 64'(99 + i));
            tick();
        end
        bus.in_rdy = 1'b0;
        chk("wrap_last", bus.out_data, 64'd109);
        tick();
        bus.out_ready = 1'b0;
        chk("wrap_empty", 64'(empty), 64'd1);
        push_n(4, 0);
        bus.in_rdy = 1'b1;
        repeat (300) tick();
        bus.in_rdy = 1'b0;
        chk("sat_drop", 64'(drop_cnt), 64'd255);
        chk("sat_ovf", 64'(overflow), 64'd1);
        chk("sat_count", 64'(count), 64'd4);
        bus.in_rdy = 1'b1; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clrwin_drop", 64'(drop_cnt), 64'd0);
        chk("clrwin_ovf", 64'(overflow), 64'd0);
        tick();
        chk("burst_drop", 64'(drop_cnt), 64'd1);
        rst = 1'b0;
        #1;
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        chk("arst_data", bus.out_data, 64'd0);
        bus.in_rdy = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
